// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, flag bit positions, bias and
// canonical NaN encodings for any exponent/fraction width.
package fp_pkg;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Returned wide; callers slice to 1+exp_w+frac_w bits.
    function automatic logic [127:0] canon_nan(input int exp_w, input int frac_w);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < exp_w; i++) r[frac_w + i] = 1'b1;
        r[frac_w - 1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fmul_mant_mult.sv
// Unsigned mantissa multiplier; kept as its own block so a tree multiplier can
// replace the behavioural product without touching the pipeline.
module fmul_mant_mult #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/fmul_pipe.sv
// Three-stage floating-point multiplier with RNE rounding, flush-to-zero and a
// single global stall enable driven by the output handshake.
module fmul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   in_a,
    input  logic [EXP_W+FRAC_W:0]   in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_res,
    output logic [3:0]              out_flags
);

    localparam int W      = 1 + EXP_W + FRAC_W;
    localparam int M      = FRAC_W + 1;
    localparam int P      = 2 * M;
    localparam int EW     = EXP_W + 2;
    localparam int STAGES = 3;
    localparam int BIAS   = bias(EXP_W);
    localparam logic [W-1:0]          QNAN   = W'(canon_nan(EXP_W, FRAC_W));
    localparam logic [EXP_W-1:0]      EXP_MX = '1;
    localparam logic signed [EW-1:0]  E_ZERO = '0;
    localparam logic signed [EW-1:0]  E_OVF  = EW'((1 << EXP_W) - 1);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
        if (e == EXP_MX) return (f != '0) ? NAN : INF;
        if (e == '0)     return ZERO;
        return NORM;
    endfunction

    logic              en;
    logic [STAGES:1]   vld_pipe;

    assign en        = out_ready | ~out_valid;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];

    // S1: classify and resolve special operands up front
    fp_class_e   cls_a, cls_b;
    logic        sign;
    logic        spec;
    logic [W-1:0] spec_res;
    logic [3:0]  spec_flags;

    assign cls_a = classify(in_a[W-2 -: EXP_W], in_a[FRAC_W-1:0]);
    assign cls_b = classify(in_b[W-2 -: EXP_W], in_b[FRAC_W-1:0]);
    assign sign  = in_a[W-1] ^ in_b[W-1];

    always_comb begin
        spec       = 1'b1;
        spec_res   = '0;
        spec_flags = '0;
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
            spec_res                 = QNAN;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            spec_res = {sign, EXP_MX, {FRAC_W{1'b0}}};
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            spec_res = {sign, {(W-1){1'b0}}};
        end else begin
            spec = 1'b0;
        end
    end

    logic              s1_sign, s1_spec;
    logic [W-1:0]      s1_spec_res;
    logic [3:0]        s1_spec_flags;
    logic [EXP_W-1:0]  s1_ea, s1_eb;
    logic [M-1:0]      s1_ma, s1_mb;

    // S2: mantissa product and biased exponent sum
    logic [P-1:0]          prod;
    logic                  s2_sign, s2_spec;
    logic [W-1:0]          s2_spec_res;
    logic [3:0]            s2_spec_flags;
    logic signed [EW-1:0]  s2_e;
    logic [P-1:0]          s2_prod;

    fmul_mant_mult #(.WIDTH(M)) u_mult (
        .a (s1_ma),
        .b (s1_mb),
        .p (prod)
    );

    // S3: normalise, round to nearest even, detect range exceptions
    logic                  norm, guard, sticky, rnd;
    logic [P-1:0]          sh;
    logic [M-1:0]          kept;
    logic [M:0]            sum;
    logic signed [EW-1:0]  e_fin;
    logic [W-1:0]          res;
    logic [3:0]            flags;

    always_comb begin
        norm   = s2_prod[P-1];
        sh     = norm ? s2_prod : (s2_prod << 1);
        kept   = sh[P-1 -: M];
        guard  = sh[P-1-M];
        sticky = |sh[P-2-M:0];
        rnd    = guard & (sticky | kept[0]);
        sum    = {1'b0, kept} + (M+1)'(rnd);
        e_fin  = s2_e + EW'(norm) + EW'(sum[M]);
        flags  = '0;
        if (s2_spec) begin
            res   = s2_spec_res;
            flags = s2_spec_flags;
        end else if (e_fin >= E_OVF) begin
            res                     = {s2_sign, EXP_MX, {FRAC_W{1'b0}}};
            flags[FLAG_OVERFLOW]    = 1'b1;
            flags[FLAG_INEXACT]     = 1'b1;
        end else if (e_fin <= E_ZERO) begin
            res                     = {s2_sign, {(W-1){1'b0}}};
            flags[FLAG_UNDERFLOW]   = 1'b1;
            flags[FLAG_INEXACT]     = 1'b1;
        end else begin
            // On rounding carry-out the low fraction bits of sum are already zero.
            res                 = {s2_sign, e_fin[EXP_W-1:0], sum[FRAC_W-1:0]};
            flags[FLAG_INEXACT] = guard | sticky;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            out_res   <= '0;
            out_flags <= '0;
        end else if (en) begin
            vld_pipe      <= {vld_pipe[STAGES-1:1], in_valid};
            s1_sign       <= sign;
            s1_spec       <= spec;
            s1_spec_res   <= spec_res;
            s1_spec_flags <= spec_flags;
            s1_ea         <= in_a[W-2 -: EXP_W];
            s1_eb         <= in_b[W-2 -: EXP_W];
            s1_ma         <= {1'b1, in_a[FRAC_W-1:0]};
            s1_mb         <= {1'b1, in_b[FRAC_W-1:0]};
            s2_sign       <= s1_sign;
            s2_spec       <= s1_spec;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_e          <= $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - EW'(BIAS);
            s2_prod       <= prod;
            out_res       <= res;
            out_flags     <= flags;
        end
    end

endmodule
